// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl
//   Steps a binary count up or down and offers each value, together with its
//   Gray-code image, to a downstream consumer over a valid/ready handshake.
//   Supports a loadable start value and either a single sweep (ends with a
//   one-cycle done pulse) or continuous wrap-around counting.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : begin a sequence (IDLE only)
//   stop       : abort the running sequence (RUN only, wins over start)
//   dir        : 0 = count up, 1 = count down (captured when start is taken)
//   continuous : 1 = wrap forever, 0 = single sweep (captured with start)
//   load       : load load_val as next start value (IDLE only)
//   load_val   : value for load
//   ready      : consumer accepts the value currently offered
//   valid      : binary/gray hold a value offered to the consumer
//   binary     : current binary count
//   gray       : binary ^ (binary >> 1), registered alongside binary
//   busy       : high while running
//   done       : one-cycle pulse after the last value of a sweep is taken
module gray_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             continuous,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q,   bin_d;
  logic [WIDTH-1:0] gray_q,  gray_d;
  logic             dir_q,   dir_d;
  logic             cont_q,  cont_d;
  logic             done_q,  done_d;

  logic             xfer;
  logic [WIDTH-1:0] end_val;

  // In RUN valid is always high, so a transfer is simply ready.
  assign xfer    = (state_q == ST_RUN) && ready;
  assign end_val = dir_q ? '0 : '1;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    dir_d   = dir_q;
    cont_d  = cont_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A load in the same cycle as start becomes the first offered value.
        if (load) begin
          bin_d = load_val;
        end
        if (start && !stop) begin
          state_d = ST_RUN;
          dir_d   = dir;
          cont_d  = continuous;
        end
      end

      ST_RUN: begin
        // stop freezes the count even if the consumer took a value this cycle.
        if (stop) begin
          state_d = ST_IDLE;
        end else if (xfer) begin
          if (!cont_q && (bin_q == end_val)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (dir_q) begin
            bin_d = bin_q - 1'b1;
          end else begin
            bin_d = bin_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Gray is derived from the next binary value so both registers update
    // in the same cycle and gray never lags.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      gray_q  <= '0;
      dir_q   <= 1'b0;
      cont_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      dir_q   <= dir_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
    end
  end

  assign valid  = (state_q == ST_RUN);
  assign busy   = (state_q == ST_RUN);
  assign binary = bin_q;
  assign gray   = gray_q;
  assign done   = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl (WIDTH=4): a table of one-cycle vectors
// with hand-computed expected outputs, plus a hand-written async reset check.
module tb_gray_seq_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         start, stop, dir, continuous, load, ready;
  logic [W-1:0] load_val;
  logic         valid, busy, done;
  logic [W-1:0] binary, gray;

  int checks = 0;
  int errors = 0;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .continuous (continuous),
    .load       (load),
    .load_val   (load_val),
    .ready      (ready),
    .valid      (valid),
    .binary     (binary),
    .gray       (gray),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         st, sp, d, c, ld;
    logic [W-1:0] lv;
    logic         rdy;
    logic         ev;
    logic [W-1:0] eb, eg;
    logic         ebusy, edone;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic st, sp, d, c, ld, input logic [W-1:0] lv,
                              input logic rdy, input logic ev,
                              input logic [W-1:0] eb, eg, input logic ebusy, edone);
    vec_t v;
    v.st = st; v.sp = sp; v.d = d; v.c = c; v.ld = ld; v.lv = lv; v.rdy = rdy;
    v.ev = ev; v.eb = eb; v.eg = eg; v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  task automatic check_out(input string name, input logic ev, input logic [W-1:0] eb,
                           input logic [W-1:0] eg, input logic ebusy, input logic edone);
    checks++;
    if (valid !== ev || binary !== eb || gray !== eg || busy !== ebusy || done !== edone) begin
      errors++;
      $display("FAIL %s: got valid=%b bin=%0d gray=%b busy=%b done=%b, expected valid=%b bin=%0d gray=%b busy=%b done=%b",
               name, valid, binary, gray, busy, done, ev, eb, eg, ebusy, edone);
    end
  endtask

  initial begin
    //             st sp d  c  ld lv     rdy  ev eb  eg        busy done
    // load, start/stop collision (stop wins, load still applies)
    tv.push_back(mk(0, 0, 0, 0, 1, 4'd5,  0,   0, 4'd5,  4'b0111, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 1, 4'd0,  0,   0, 4'd0,  4'b0000, 0, 0));
    // single sweep up from 0, initial backpressure, load/start ignored in RUN
    tv.push_back(mk(1, 0, 0, 0, 0, 4'd0,  0,   1, 4'd0,  4'b0000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  0,   1, 4'd0,  4'b0000, 1, 0));
    tv.push_back(mk(1, 0, 0, 0, 1, 4'd12, 1,   1, 4'd1,  4'b0001, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd2,  4'b0011, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd3,  4'b0010, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd4,  4'b0110, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd5,  4'b0111, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd6,  4'b0101, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd7,  4'b0100, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd8,  4'b1100, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd9,  4'b1101, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd10, 4'b1111, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd11, 4'b1110, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd12, 4'b1010, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd13, 4'b1011, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd14, 4'b1001, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd15, 4'b1000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   0, 4'd15, 4'b1000, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   0, 4'd15, 4'b1000, 0, 0));
    // restart at end value: one-value sweep
    tv.push_back(mk(1, 0, 0, 0, 0, 4'd0,  0,   1, 4'd15, 4'b1000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   0, 4'd15, 4'b1000, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  0,   0, 4'd15, 4'b1000, 0, 0));
    // stop with simultaneous transfer at 9
    tv.push_back(mk(0, 0, 0, 0, 1, 4'd9,  0,   0, 4'd9,  4'b1101, 0, 0));
    tv.push_back(mk(1, 0, 0, 0, 0, 4'd0,  0,   1, 4'd9,  4'b1101, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 4'd0,  1,   0, 4'd9,  4'b1101, 0, 0));
    // continuous down with backpressure; dir/continuous/start/load ignored in RUN
    tv.push_back(mk(0, 0, 0, 0, 1, 4'd1,  0,   0, 4'd1,  4'b0001, 0, 0));
    tv.push_back(mk(1, 0, 1, 1, 0, 4'd0,  0,   1, 4'd1,  4'b0001, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd0,  4'b0000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  0,   1, 4'd0,  4'b0000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd15, 4'b1000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  0,   1, 4'd15, 4'b1000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd14, 4'b1001, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd13, 4'b1011, 1, 0));
    tv.push_back(mk(1, 0, 0, 0, 1, 4'd3,  0,   1, 4'd13, 4'b1011, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd12, 4'b1010, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 4'd0,  0,   0, 4'd12, 4'b1010, 0, 0));
    // continuous up wrap 15 -> 0, no done
    tv.push_back(mk(0, 0, 0, 0, 1, 4'd14, 0,   0, 4'd14, 4'b1001, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, 4'd0,  1,   1, 4'd14, 4'b1001, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd15, 4'b1000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd0,  4'b0000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd1,  4'b0001, 1, 0));
    tv.push_back(mk(0, 1, 0, 0, 0, 4'd0,  0,   0, 4'd1,  4'b0001, 0, 0));
    // single sweep down ending at 0
    tv.push_back(mk(1, 0, 1, 0, 0, 4'd0,  0,   1, 4'd1,  4'b0001, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   1, 4'd0,  4'b0000, 1, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  1,   0, 4'd0,  4'b0000, 0, 1));
    tv.push_back(mk(0, 0, 0, 0, 0, 4'd0,  0,   0, 4'd0,  4'b0000, 0, 0));

    rst_n = 1'b0;
    start = 1'b0; stop = 1'b0; dir = 1'b0; continuous = 1'b0;
    load = 1'b0; load_val = '0; ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_out("reset", 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      start = tv[i].st; stop = tv[i].sp; dir = tv[i].d; continuous = tv[i].c;
      load = tv[i].ld; load_val = tv[i].lv; ready = tv[i].rdy;
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), tv[i].ev, tv[i].eb, tv[i].eg, tv[i].ebusy, tv[i].edone);
    end

    // Asynchronous reset mid-RUN at binary=6, between clock edges.
    @(negedge clk);
    start = 1'b1; stop = 1'b0; dir = 1'b0; continuous = 1'b1;
    load = 1'b1; load_val = 4'd6; ready = 1'b0;
    @(posedge clk);
    #1;
    check_out("run_at_6", 1'b1, 4'd6, 4'b0101, 1'b1, 1'b0);
    start = 1'b0; load = 1'b0; ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_rst_idle", 1'b0, 4'd0, 4'b0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
